sipo_buffer: RTL and testbench

//  Receive-side counterpart of the BPSK TX parallel-to-serial stage.
//  - Takes the demodulated bit stream one bit per 'active' strobe, MSB first.
//  - Optionally hunts for a sync word, then assembles WIDTH-bit words and

---
 rtl/bpsk_pkg.sv | 11 +
 rtl/sipo_sync_detector.sv | 43 ++++
 rtl/sipo_buffer.sv | 110 +++++++++++
 tb/tb_sipo_buffer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bpsk_pkg.sv
// Shared types and constants for the BPSK receive path.
package bpsk_pkg;

    typedef enum logic {
        SIPO_HUNT   = 1'b0,
        SIPO_LOCKED = 1'b1
    } sipo_state_t;

    localparam logic [31:0] SIPO_SYNC_DEFAULT = 32'hD391_D391;

endpackage

// File: rtl/sipo_sync_detector.sv
// Serial shift register with fill tracking and sync-word comparison.
module sipo_sync_detector
    import bpsk_pkg::*;
#(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  SYNC_WORD = WIDTH'(SIPO_SYNC_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift,
    input  logic             clear,
    input  logic             serial_signal,
    output logic [WIDTH-1:0] sr_next,
    output logic             match
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    fill_cnt;

    assign sr_next = {sr[WIDTH-2:0], serial_signal};

    // Only a window made entirely of received bits may match, so reset zeros never do.
    assign match = (fill_cnt >= CW'(WIDTH - 1)) && (sr_next == SYNC_WORD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr       <= '0;
            fill_cnt <= '0;
        end else begin
            if (shift) begin
                sr <= sr_next;
            end
            if (clear) begin
                fill_cnt <= '0;
            end else if (shift && (fill_cnt != CW'(WIDTH))) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sipo_buffer.sv
// Serial-to-parallel receiver: sync hunt, word assembly and valid/ready holding register.
module sipo_buffer
    import bpsk_pkg::*;
#(
    parameter int unsigned       WIDTH       = 32,
    parameter logic [WIDTH-1:0]  SYNC_WORD   = WIDTH'(SIPO_SYNC_DEFAULT),
    parameter int unsigned       USE_SYNC    = 1,
    parameter int unsigned       FRAME_WORDS = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             active,
    input  logic             serial_signal,
    input  logic             resync,
    input  logic             ready,
    output logic [WIDTH-1:0] parallel,
    output logic             valid,
    output logic             locked,
    output logic             overrun
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned FW = (FRAME_WORDS > 0) ? $clog2(FRAME_WORDS + 1) : 1;
    localparam sipo_state_t INIT_STATE = (USE_SYNC != 0) ? SIPO_HUNT : SIPO_LOCKED;

    sipo_state_t      state;
    logic [CW-1:0]    bit_cnt;
    logic [FW-1:0]    word_cnt;
    logic [WIDTH-1:0] sr_next;
    logic             match;

    logic shift_c;
    logic word_done_c;
    logic frame_end_c;
    logic accept_c;

    // resync outranks the bit strobe, so nothing shifts or completes on that cycle.
    assign shift_c     = active && !resync;
    assign word_done_c = shift_c && (state == SIPO_LOCKED) && (bit_cnt == CW'(WIDTH - 1));
    assign frame_end_c = word_done_c && (FRAME_WORDS != 0) && (word_cnt == FW'(FRAME_WORDS - 1));
    assign accept_c    = valid && ready;
    assign locked      = (state == SIPO_LOCKED);

    sipo_sync_detector #(
        .WIDTH     (WIDTH),
        .SYNC_WORD (SYNC_WORD)
    ) u_sync (
        .clk           (clk),
        .reset         (reset),
        .shift         (shift_c),
        .clear         (resync || frame_end_c),
        .serial_signal (serial_signal),
        .sr_next       (sr_next),
        .match         (match)
    );

    // Lock FSM, bit/word counters and output holding register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= INIT_STATE;
            bit_cnt  <= '0;
            word_cnt <= '0;
            parallel <= '0;
            valid    <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (accept_c) begin
                valid <= 1'b0;
            end
            if (resync) begin
                state    <= INIT_STATE;
                bit_cnt  <= '0;
                word_cnt <= '0;
                overrun  <= 1'b0;
            end else if (active) begin
                case (state)
                    SIPO_HUNT: begin
                        if (match) begin
                            state    <= SIPO_LOCKED;
                            bit_cnt  <= '0;
                            word_cnt <= '0;
                        end
                    end
                    SIPO_LOCKED: begin
                        if (word_done_c) begin
                            bit_cnt <= '0;
                            // A full holding register that is not draining this cycle drops the new word.
                            if (!valid || accept_c) begin
                                parallel <= sr_next;
                                valid    <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                            if (frame_end_c) begin
                                state    <= SIPO_HUNT;
                                word_cnt <= '0;
                            end else begin
                                word_cnt <= word_cnt + 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: state <= INIT_STATE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sipo_buffer.sv
// Self-checking bench for sipo_buffer: a free-running instance and a sync/framed instance.
module tb_sipo_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, act_a, ser_a, rsy_a, rdy_a;
    logic [7:0] par_a;
    logic       valid_a, locked_a, overrun_a;

    logic       rst_b, act_b, ser_b, rsy_b, rdy_b;
    logic [7:0] par_b;
    logic       valid_b, locked_b, overrun_b;

    sipo_buffer #(.WIDTH(8), .SYNC_WORD(8'hD5), .USE_SYNC(0), .FRAME_WORDS(0)) dut_a (
        .clk(clk), .reset(rst_a), .active(act_a), .serial_signal(ser_a),
        .resync(rsy_a), .ready(rdy_a), .parallel(par_a), .valid(valid_a),
        .locked(locked_a), .overrun(overrun_a)
    );

    sipo_buffer #(.WIDTH(8), .SYNC_WORD(8'hD5), .USE_SYNC(1), .FRAME_WORDS(2)) dut_b (
        .clk(clk), .reset(rst_b), .active(act_b), .serial_signal(ser_b),
        .resync(rsy_b), .ready(rdy_b), .parallel(par_b), .valid(valid_b),
        .locked(locked_b), .overrun(overrun_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb_a[$];
    logic [7:0] sb_b[$];
    logic [7:0] exp_a, exp_b;

    typedef struct {
        logic [7:0] bits;
        logic [7:0] exp_word;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboards: a word is consumed on the edge after valid&&ready is seen.
    always @(negedge clk) begin
        if (valid_a && rdy_a) begin
            if (sb_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_a: unexpected word %h, required none", par_a);
            end else begin
                exp_a = sb_a.pop_front();
                check("sb_a", par_a, exp_a);
            end
        end
        if (valid_b && rdy_b) begin
            if (sb_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_b: unexpected word %h, required none", par_b);
            end else begin
                exp_b = sb_b.pop_front();
                check("sb_b", par_b, exp_b);
            end
        end
    end

    task automatic send_bit(input int s, input logic b);
        if (s == 0) begin act_a = 1'b1; ser_a = b; end
        else        begin act_b = 1'b1; ser_b = b; end
        @(posedge clk); #1;
        act_a = 1'b0;
        act_b = 1'b0;
    endtask

    task automatic send_word(input int s, input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(s, w[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] w;
        vecs[0] = '{bits: 8'b1010_0110, exp_word: 8'hA6, exp_valid: 1'b1};
        vecs[1] = '{bits: 8'b0011_1100, exp_word: 8'h3C, exp_valid: 1'b1};
        vecs[2] = '{bits: 8'b1111_1111, exp_word: 8'hFF, exp_valid: 1'b1};
        vecs[3] = '{bits: 8'b0000_0001, exp_word: 8'h01, exp_valid: 1'b1};

        rst_a = 1'b1; act_a = 1'b0; ser_a = 1'b0; rsy_a = 1'b0; rdy_a = 1'b1;
        rst_b = 1'b1; act_b = 1'b0; ser_b = 1'b0; rsy_b = 1'b0; rdy_b = 1'b1;
        @(posedge clk); #1;
        check("rst par_a", par_a, 8'h00);
        check("rst valid_a", 8'(valid_a), 8'd0);
        check("rst locked_a", 8'(locked_a), 8'd1);
        check("rst overrun_a", 8'(overrun_a), 8'd0);
        check("rst locked_b", 8'(locked_b), 8'd0);
        check("rst valid_b", 8'(valid_b), 8'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        idle(1);

        // Free-running assembly, ready held high, words back to back.
        for (int v = 0; v < 4; v++) begin
            send_word(0, vecs[v].bits);
            sb_a.push_back(vecs[v].exp_word);
            check("vec par_a", par_a, vecs[v].exp_word);
            check("vec valid_a", 8'(valid_a), 8'(vecs[v].exp_valid));
        end
        idle(1);
        check("vec valid_a drop", 8'(valid_a), 8'd0);

        // Consumer stalled: second word dropped, sticky overrun.
        rdy_a = 1'b0;
        send_word(0, 8'h11);
        sb_a.push_back(8'h11);
        check("stall par_a", par_a, 8'h11);
        check("stall valid_a", 8'(valid_a), 8'd1);
        send_word(0, 8'h22);
        check("ovr par_a", par_a, 8'h11);
        check("ovr overrun_a", 8'(overrun_a), 8'd1);
        rdy_a = 1'b1;
        idle(1);
        check("drain valid_a", 8'(valid_a), 8'd0);
        check("sticky overrun_a", 8'(overrun_a), 8'd1);
        rsy_a = 1'b1;
        idle(1);
        rsy_a = 1'b0;
        check("resync overrun_a", 8'(overrun_a), 8'd0);
        check("resync locked_a", 8'(locked_a), 8'd1);

        // Accept and completion on the same edge.
        rdy_a = 1'b0;
        send_word(0, 8'h77);
        sb_a.push_back(8'h77);
        w = 8'h5A;
        for (int i = 7; i >= 1; i--) send_bit(0, w[i]);
        rdy_a = 1'b1;
        send_bit(0, w[0]);
        sb_a.push_back(8'h5A);
        check("same-edge par_a", par_a, 8'h5A);
        check("same-edge valid_a", 8'(valid_a), 8'd1);
        check("same-edge overrun_a", 8'(overrun_a), 8'd0);
        idle(1);
        check("same-edge drain", 8'(valid_a), 8'd0);

        // Async reset mid-word discards the partial word and the held word.
        rdy_a = 1'b0;
        send_word(0, 8'hC3);
        check("pre-rst valid_a", 8'(valid_a), 8'd1);
        w = 8'h90;
        for (int i = 7; i >= 4; i--) send_bit(0, w[i]);
        rst_a = 1'b1;
        #1;
        check("async par_a", par_a, 8'h00);
        check("async valid_a", 8'(valid_a), 8'd0);
        check("async overrun_a", 8'(overrun_a), 8'd0);
        check("async locked_a", 8'(locked_a), 8'd1);
        @(posedge clk); #1;
        rst_a = 1'b0;
        rdy_a = 1'b1;
        send_word(0, 8'h69);
        sb_a.push_back(8'h69);
        check("post-rst par_a", par_a, 8'h69);
        check("post-rst valid_a", 8'(valid_a), 8'd1);
        idle(1);

        // Sync hunt: D5 locks and is never delivered.
        send_word(1, 8'h00);
        check("hunt locked_b", 8'(locked_b), 8'd0);
        send_word(1, 8'hD5);
        check("sync locked_b", 8'(locked_b), 8'd1);
        check("sync valid_b", 8'(valid_b), 8'd0);
        send_word(1, 8'h3C);
        sb_b.push_back(8'h3C);
        check("word par_b", par_b, 8'h3C);
        check("word valid_b", 8'(valid_b), 8'd1);
        idle(1);

        // Two-word frame, then back to hunting.
        rsy_b = 1'b1;
        idle(1);
        rsy_b = 1'b0;
        check("resync locked_b", 8'(locked_b), 8'd0);
        send_word(1, 8'hD5);
        check("frame lock", 8'(locked_b), 8'd1);
        send_word(1, 8'h41);
        sb_b.push_back(8'h41);
        check("frame w1 par_b", par_b, 8'h41);
        check("frame w1 locked_b", 8'(locked_b), 8'd1);
        send_word(1, 8'h42);
        sb_b.push_back(8'h42);
        check("frame w2 par_b", par_b, 8'h42);
        check("frame end locked_b", 8'(locked_b), 8'd0);
        send_word(1, 8'h43);
        check("hunt data valid_b", 8'(valid_b), 8'd0);
        check("hunt data locked_b", 8'(locked_b), 8'd0);
        idle(1);

        // resync mid-word with a held word and overrun pending.
        send_word(1, 8'hD5);
        check("relock locked_b", 8'(locked_b), 8'd1);
        rdy_b = 1'b0;
        send_word(1, 8'h81);
        sb_b.push_back(8'h81);
        send_word(1, 8'h82);
        check("b ovr overrun_b", 8'(overrun_b), 8'd1);
        check("b ovr par_b", par_b, 8'h81);
        w = 8'hA0;
        for (int i = 7; i >= 4; i--) send_bit(1, w[i]);
        rsy_b = 1'b1; act_b = 1'b1; ser_b = 1'b1;
        @(posedge clk); #1;
        rsy_b = 1'b0; act_b = 1'b0;
        check("mid resync locked_b", 8'(locked_b), 8'd0);
        check("mid resync overrun_b", 8'(overrun_b), 8'd0);
        check("mid resync valid_b", 8'(valid_b), 8'd1);
        check("mid resync par_b", par_b, 8'h81);
        rdy_b = 1'b1;
        idle(1);
        check("mid resync drain", 8'(valid_b), 8'd0);
        idle(2);

        check("sb_a leftover", 8'(sb_a.size()), 8'd0);
        check("sb_b leftover", 8'(sb_b.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
